// File: rtl/switch_poll_controller.sv
// Avalon-MM master that polls the switch PIO, debounces it and publishes a stable vector.
// Optional sticky change interrupt, enabled by defining SWPOLL_IRQ_EN.
module switch_poll_controller #(
  parameter int WIDTH      = 18,
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       m_address,
  output logic             m_read,
  input  logic [31:0]      m_readdata,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [WIDTH-1:0] change_mask,
  output logic             irq,
  input  logic             irq_ack
);

  localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_EVAL    = 2'd3;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] match_cnt;
  logic [WIDTH-1:0] next_cand;
  logic [CNT_W-1:0] next_cnt;
  logic             accept;

  assign m_read    = (state == S_ISSUE);
  assign m_address = 2'b00;
  assign tick      = enable && (div_cnt == DIV_LAST);

  generate
    if (WIDTH < 32) begin : g_unused_rd
      logic unused_rd;
      assign unused_rd = ^m_readdata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Post-update debounce state; accept is only meaningful during EVAL.
  always_comb begin
    next_cand = candidate;
    next_cnt  = match_cnt;
    if (sample != candidate) begin
      next_cand = sample;
      next_cnt  = '0;
    end else if (match_cnt != CNT_MAX) begin
      next_cnt = match_cnt + 1'b1;
    end
    accept = (state == S_EVAL) && (next_cnt == CNT_MAX) && (next_cand != sw_stable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sample      <= '0;
      candidate   <= '0;
      match_cnt   <= '0;
      sw_stable   <= '0;
      change_mask <= '0;
      sw_changed  <= 1'b0;
    end else begin
      sw_changed <= accept;
      case (state)
        S_IDLE: begin
          if (tick) state <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          sample <= m_readdata[WIDTH-1:0];
          state  <= S_EVAL;
        end
        S_EVAL: begin
          candidate <= next_cand;
          match_cnt <= next_cnt;
          if (accept) begin
            change_mask <= sw_stable ^ next_cand;
            sw_stable   <= next_cand;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SWPOLL_IRQ_EN
  logic irq_q;

  // An ack landing in the same cycle as a change pulse must not drop the new event.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (accept) begin
      irq_q <= 1'b1;
    end else if (irq_ack && !sw_changed) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_ack;
  assign unused_ack = irq_ack;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_switch_poll_controller.sv
// Bench for switch_poll_controller: PIO slave model plus a per-poll debounce reference.
module tb_switch_poll_controller;
  localparam int W  = 18;
  localparam int PD = 8;
  localparam int SC = 3;
`ifdef SWPOLL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          irq_ack = 1'b0;
  logic [31:0]   m_readdata = '0;
  logic [1:0]    m_address;
  logic          m_read;
  logic [W-1:0]  sw_stable;
  logic          sw_changed;
  logic [W-1:0]  change_mask;
  logic          irq;

  logic [W-1:0]  sw_in = '0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  // Reference model: history of polled values and pending visible updates.
  logic [W-1:0]  hist[$];
  int            pend_due[$];
  logic [W-1:0]  pend_val[$];
  logic [W-1:0]  pend_mask[$];
  logic [W-1:0]  mdl_stable = '0;
  logic [W-1:0]  exp_stable = '0;
  logic [W-1:0]  exp_mask = '0;
  logic          exp_changed = 1'b0;
  logic          exp_irq = 1'b0;

  switch_poll_controller #(.WIDTH(W), .POLL_DIV(PD), .STABLE_CNT(SC)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .sw_stable(sw_stable), .sw_changed(sw_changed), .change_mask(change_mask),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // PIO slave: registered readdata, upper bits deliberately nonzero.
  always @(posedge clk) if (m_read) m_readdata <= 32'hFFFC0000 | {14'd0, sw_in};

  function automatic bit last_sc_equal(input logic [W-1:0] v);
    if (hist.size() < SC) return 1'b0;
    for (int i = 0; i < SC; i++)
      if (hist[hist.size()-1-i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle();
    logic pre_read, pre_rst, pre_ack, pre_chg;
    logic [W-1:0] v;
    pre_read = m_read; pre_rst = reset; pre_ack = irq_ack; pre_chg = exp_changed; v = sw_in;
    @(posedge clk); #1;
    cyc++;
    exp_changed = 1'b0;
    if (pre_rst) begin
      hist.delete(); pend_due.delete(); pend_val.delete(); pend_mask.delete();
      mdl_stable = '0; exp_stable = '0; exp_mask = '0; exp_irq = 1'b0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        exp_stable = pend_val[0]; exp_mask = pend_mask[0]; exp_changed = 1'b1;
        pend_due.delete(0); pend_val.delete(0); pend_mask.delete(0);
      end
      if (IRQ_ON) begin
        if (exp_changed) exp_irq = 1'b1;
        else if (pre_ack && !pre_chg) exp_irq = 1'b0;
      end
      if (pre_read === 1'b1) begin
        hist.push_back(v);
        if (hist.size() > SC) hist.delete(0);
        // Read in cycle c -> capture c+1 -> eval c+2 -> visible c+3.
        if (last_sc_equal(v) && v != mdl_stable) begin
          pend_due.push_back(cyc + 2); pend_val.push_back(v); pend_mask.push_back(mdl_stable ^ v);
          mdl_stable = v;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sw_in = '0;
    repeat (3) cycle();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      checks++;
      if ({m_read, m_address, sw_stable, sw_changed, change_mask, irq} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got rd=%b st=%h chg=%b mask=%h irq=%b want all 0",
                 cyc, m_read, sw_stable, sw_changed, change_mask, irq);
      end
    end
  endtask

  task automatic test_cadence();
    int start, last, nreads;
    enable = 1'b1; sw_in = '0; start = cyc; last = -1; nreads = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (m_read === 1'b1) begin
        nreads++;
        checks++;
        if (m_address !== 2'b00) begin
          errors++; $display("FAIL cadence_addr got %h want 0", m_address);
        end
        checks++;
        if ((last < 0 ? cyc - start : cyc - last) != PD) begin
          errors++; $display("FAIL cadence_gap cyc=%0d got %0d want %0d", cyc, (last < 0 ? cyc - start : cyc - last), PD);
        end
        last = cyc;
      end
      if (sw_changed !== 1'b0) begin
        checks++; errors++; $display("FAIL cadence_nochange got sw_changed=%b want 0", sw_changed);
      end
    end
    checks++;
    if (nreads != 10) begin
      errors++; $display("FAIL cadence_count got %0d want 10", nreads);
    end
  endtask

  task automatic test_accept();
    logic [W-1:0] vals[3] = '{18'h2A5, 18'h2A4, 18'h2A5};
    logic [W-1:0] masks[3] = '{18'h2A5, 18'h001, 18'h001};
    for (int k = 0; k < 3; k++) begin
      int nchg;
      nchg = 0; sw_in = vals[k];
      for (int i = 0; i < 40; i++) begin
        cycle();
        if (sw_changed === 1'b1) nchg++;
        checks++;
        if ({sw_stable, change_mask, sw_changed, irq, m_address} !== {exp_stable, exp_mask, exp_changed, exp_irq, 2'b00}) begin
          errors++;
          $display("FAIL accept_cycle cyc=%0d got st=%h mask=%h chg=%b irq=%b want st=%h mask=%h chg=%b irq=%b",
                   cyc, sw_stable, change_mask, sw_changed, irq, exp_stable, exp_mask, exp_changed, exp_irq);
        end
      end
      checks++;
      if (sw_stable !== vals[k] || change_mask !== masks[k] || nchg != 1) begin
        errors++;
        $display("FAIL accept_%0d got st=%h mask=%h pulses=%0d want st=%h mask=%h pulses=1",
                 k, sw_stable, change_mask, nchg, vals[k], masks[k]);
      end
    end
  endtask

  task automatic test_bounce();
    int nreads, nchg;
    nreads = 0; nchg = 0;
    for (int i = 0; i < 200 && nreads < 10; i++) begin
      cycle();
      if (sw_changed === 1'b1) nchg++;
      if (m_read === 1'b1) begin
        nreads++;
        sw_in = (sw_in == 18'h2A5) ? 18'h0 : 18'h2A5;
      end
    end
    sw_in = 18'h2A5;
    repeat (10) begin
      cycle();
      if (sw_changed === 1'b1) nchg++;
    end
    checks++;
    if (nreads != 10 || nchg != 0 || sw_stable !== 18'h2A5) begin
      errors++;
      $display("FAIL bounce got polls=%0d pulses=%0d st=%h want polls=10 pulses=0 st=2a5", nreads, nchg, sw_stable);
    end
  endtask

  task automatic test_enable_drop_reset();
    int nreads, nchg, start;
    bit seen;
    nreads = 0; nchg = 0; sw_in = 18'h155;
    for (int i = 0; i < 60 && nreads < 3; i++) begin
      cycle();
      if (m_read === 1'b1) nreads++;
    end
    enable = 1'b0;
    nreads = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_read === 1'b1) nreads++;
      if (sw_changed === 1'b1) nchg++;
      checks++;
      if ({sw_stable, change_mask, sw_changed, irq} !== {exp_stable, exp_mask, exp_changed, exp_irq}) begin
        errors++;
        $display("FAIL drop_cycle cyc=%0d got st=%h mask=%h chg=%b want st=%h mask=%h chg=%b",
                 cyc, sw_stable, change_mask, sw_changed, exp_stable, exp_mask, exp_changed);
      end
    end
    checks++;
    if (nreads != 0 || nchg != 1 || sw_stable !== 18'h155) begin
      errors++;
      $display("FAIL enable_drop got reads=%0d pulses=%0d st=%h want reads=0 pulses=1 st=155", nreads, nchg, sw_stable);
    end
    // Reset during CAPTURE of a fresh poll.
    enable = 1'b1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      seen = (m_read === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_mid_wait got no m_read want one within 40 cycles");
    end
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (sw_stable !== '0 || m_read !== 1'b0 || change_mask !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got st=%h rd=%b mask=%h irq=%b want 0", sw_stable, m_read, change_mask, irq);
    end
    start = cyc; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = (m_read === 1'b1);
    end
    checks++;
    if (!seen || cyc != start + PD) begin
      errors++; $display("FAIL reset_first_poll got offset=%0d seen=%b want %0d", cyc - start, seen, PD);
    end
    repeat (40) cycle();
    checks++;
    if (sw_stable !== 18'h155 || change_mask !== 18'h155) begin
      errors++; $display("FAIL reset_reaccept got st=%h mask=%h want 155/155", sw_stable, change_mask);
    end
  endtask

  task automatic test_irq();
    bit seen;
    checks++;
    if (irq !== IRQ_ON) begin
      errors++; $display("FAIL irq_held got %b want %b", irq, IRQ_ON);
    end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_ack_clear got %b want 0", irq);
    end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_ack_idle got %b want 0", irq);
    end
    sw_in = 18'h0F0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = (sw_changed === 1'b1);
    end
    checks++;
    if (!seen || irq !== IRQ_ON) begin
      errors++; $display("FAIL irq_set got seen=%b irq=%b want seen=1 irq=%b", seen, irq, IRQ_ON);
    end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    checks++;
    if (irq !== IRQ_ON) begin
      errors++; $display("FAIL irq_set_wins got %b want %b", irq, IRQ_ON);
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      checks++;
      if ({sw_stable, change_mask, sw_changed, irq, m_address} !== {exp_stable, exp_mask, exp_changed, exp_irq, 2'b00}) begin
        errors++;
        $display("FAIL random cyc=%0d got st=%h mask=%h chg=%b irq=%b want st=%h mask=%h chg=%b irq=%b",
                 cyc, sw_stable, change_mask, sw_changed, irq, exp_stable, exp_mask, exp_changed, exp_irq);
      end
      if ($urandom_range(39) == 0) sw_in = W'($urandom);
      irq_ack = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) enable = ~enable;
      reset = ($urandom_range(599) == 0);
    end
    reset = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_accept();
    test_bounce();
    test_enable_drop_reset();
    test_irq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
